sprite_commit_ctrl: RTL and testbench

Frame-synchronous register controller between the host bus and the sprite renderer.
- Host writes to sprite positions, enable mask and score are captured in a shadow bank.
- The shadow bank is copied to the live bank only at the start of vertical blanking, so the renderer never sees a half-updated frame.
- The block also owns the dino walk-cycle animation phase, stepped on frame ticks instead of a free-running clock divider.
- It sits between the bus slave port and the pixel-drawing logic, alongside `vga_counters`.

---
 rtl/sprite_regs_pkg.sv | 35 +++
 rtl/anim_sequencer.sv | 41 ++++
 rtl/sprite_commit_ctrl.sv | 152 +++++++++++++++
 tb/tb_sprite_commit_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_regs_pkg
//  Purpose  : Shared constants, register map and FSM encoding for the
//             frame-synchronous sprite register controller.
//  Revision : 1.0  initial release
// ============================================================================
package sprite_regs_pkg;

  // Default geometry of the sprite bank
  localparam int DEF_NSPRITE = 6;
  localparam int DEF_COORD_W = 8;

  // Register index of a control register placed after the 2*N coordinate slots
  function automatic logic [8:0] reg_addr(input int nsprite, input int offset);
    return 9'(2 * nsprite + offset);
  endfunction

  // Register map for the default geometry
  localparam logic [8:0] ADDR_SCORE  = reg_addr(DEF_NSPRITE, 0);
  localparam logic [8:0] ADDR_EN     = reg_addr(DEF_NSPRITE, 1);
  localparam logic [8:0] ADDR_COMMIT = reg_addr(DEF_NSPRITE, 2);
  localparam logic [8:0] ADDR_CTRL   = reg_addr(DEF_NSPRITE, 3);

  // Frames per animation step out of reset
  localparam logic [7:0] ANIM_PERIOD_RST = 8'd6;

  // Commit state machine
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } commit_state_t;

endpackage
`default_nettype wire

// File: rtl/anim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : anim_sequencer
//  Purpose  : Frame divider plus 3-phase counter driving the dino walk cycle.
//             Steps once every PERIOD frame ticks; PERIOD=0 freezes it.
//  Revision : 1.0  initial release
// ============================================================================
module anim_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] period,
  input  logic       clr,
  output logic [1:0] phase
);

  logic [7:0] r_count;
  logic [1:0] r_phase;

  // Frame divider and phase stepper; a clear wins over a coincident tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_phase <= 2'd0;
    end else if (clr) begin
      r_count <= '0;
    end else if (tick && (period != 8'd0)) begin
      // >= keeps the divider from running away if it ever exceeds the period
      if (r_count >= (period - 8'd1)) begin
        r_count <= '0;
        r_phase <= (r_phase == 2'd2) ? 2'd0 : (r_phase + 2'd1);
      end else begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/sprite_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_commit_ctrl
//  Purpose  : Host-written shadow bank for sprite positions, enable mask and
//             score, copied to the live bank on the frame tick that starts
//             vertical blanking. Also owns the dino animation phase.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_commit_ctrl
  import sprite_regs_pkg::*;
#(
  parameter int NSPRITE = DEF_NSPRITE,
  parameter int COORD_W = DEF_COORD_W,
  parameter int VACTIVE = 480
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       chipselect,
  input  logic                       write,
  input  logic [8:0]                 address,
  input  logic [31:0]                writedata,
  input  logic [10:0]                hcount,
  input  logic [9:0]                 vcount,
  output logic [NSPRITE*COORD_W-1:0] live_x,
  output logic [NSPRITE*COORD_W-1:0] live_y,
  output logic [NSPRITE-1:0]         live_en,
  output logic [15:0]                live_score,
  output logic [1:0]                 anim_phase,
  output logic                       commit_pending,
  output logic                       commit_done
);

  localparam logic [8:0] A_SCORE  = reg_addr(NSPRITE, 0);
  localparam logic [8:0] A_EN     = reg_addr(NSPRITE, 1);
  localparam logic [8:0] A_COMMIT = reg_addr(NSPRITE, 2);
  localparam logic [8:0] A_CTRL   = reg_addr(NSPRITE, 3);

  // Shadow bank
  logic [NSPRITE*COORD_W-1:0] r_shadow_x;
  logic [NSPRITE*COORD_W-1:0] r_shadow_y;
  logic [NSPRITE-1:0]         r_shadow_en;
  logic [15:0]                r_shadow_score;

  // Live bank
  logic [NSPRITE*COORD_W-1:0] r_live_x;
  logic [NSPRITE*COORD_W-1:0] r_live_y;
  logic [NSPRITE-1:0]         r_live_en;
  logic [15:0]                r_live_score;

  // Control
  logic          r_auto;
  logic [7:0]    r_period;
  logic          r_done;
  commit_state_t r_state;
  commit_state_t w_state_next;

  logic w_tick;
  logic w_wr;
  logic w_commit_wr;
  logic w_ctrl_wr;
  logic w_fire;

  // hcount advances every clk, so this matches for exactly one cycle per frame
  assign w_tick      = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
  assign w_wr        = chipselect && write;
  assign w_commit_wr = w_wr && (address == A_COMMIT);
  assign w_ctrl_wr   = w_wr && (address == A_CTRL);
  assign w_fire      = (r_state == ST_ARMED) && w_tick;

  // Host writes into the shadow bank; unmapped addresses fall through
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow_x     <= '0;
      r_shadow_y     <= '0;
      r_shadow_en    <= '0;
      r_shadow_score <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NSPRITE; i++) begin
        if (address == 9'(2 * i))
          r_shadow_x[i*COORD_W +: COORD_W] <= writedata[COORD_W-1:0];
        if (address == 9'(2 * i + 1))
          r_shadow_y[i*COORD_W +: COORD_W] <= writedata[COORD_W-1:0];
      end
      if (address == A_SCORE) r_shadow_score <= writedata[15:0];
      if (address == A_EN)    r_shadow_en    <= writedata[NSPRITE-1:0];
    end
  end

  // Live bank copy; nonblocking read means a same-edge shadow write is missed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live_x     <= '0;
      r_live_y     <= '0;
      r_live_en    <= '0;
      r_live_score <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_fire;
      if (w_fire) begin
        r_live_x     <= r_shadow_x;
        r_live_y     <= r_shadow_y;
        r_live_en    <= r_shadow_en;
        r_live_score <= r_shadow_score;
      end
    end
  end

  // CTRL register, applied immediately rather than through the shadow bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_auto   <= 1'b0;
      r_period <= ANIM_PERIOD_RST;
    end else if (w_ctrl_wr) begin
      r_auto   <= writedata[0];
      r_period <= writedata[15:8];
    end
  end

  // Commit state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state: a tick while IDLE only arms, so a commit never shares its arming cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_commit_wr || (w_tick && r_auto)) w_state_next = ST_ARMED;
      ST_ARMED: if (w_tick) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  anim_sequencer u_anim (
    .clk    (clk),
    .reset  (reset),
    .tick   (w_tick),
    .period (r_period),
    .clr    (w_ctrl_wr),
    .phase  (anim_phase)
  );

  assign live_x         = r_live_x;
  assign live_y         = r_live_y;
  assign live_en        = r_live_en;
  assign live_score     = r_live_score;
  assign commit_pending = (r_state == ST_ARMED);
  assign commit_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_commit_ctrl
//  Purpose  : Directed, table-driven bench for sprite_commit_ctrl with
//             hand-written sequences for reset and default animation period.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_commit_ctrl;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [47:0] live_x;
  logic [47:0] live_y;
  logic [5:0]  live_en;
  logic [15:0] live_score;
  logic [1:0]  anim_phase;
  logic        commit_pending;
  logic        commit_done;

  int checks   = 0;
  int failures = 0;

  sprite_commit_ctrl #(.NSPRITE(6), .COORD_W(8), .VACTIVE(480)) dut (
    .clk            (clk),
    .reset          (reset),
    .chipselect     (chipselect),
    .write          (write),
    .address        (address),
    .writedata      (writedata),
    .hcount         (hcount),
    .vcount         (vcount),
    .live_x         (live_x),
    .live_y         (live_y),
    .live_en        (live_en),
    .live_score     (live_score),
    .anim_phase     (anim_phase),
    .commit_pending (commit_pending),
    .commit_done    (commit_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 no tick, 1 frame tick, 2 near miss (hcount=1), 3 near miss (vcount=479)
  typedef struct {
    logic [1:0]  kind;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [7:0]  x0;
    logic [7:0]  y0;
    logic [7:0]  y1;
    logic [5:0]  en;
    logic [15:0] score;
    logic        pend;
    logic        done;
    logic [1:0]  phase;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] kind, input logic wr, input logic [8:0] addr,
                              input logic [31:0] data, input logic [7:0] x0, input logic [7:0] y0,
                              input logic [7:0] y1, input logic [5:0] en, input logic [15:0] score,
                              input logic pend, input logic done, input logic [1:0] phase);
    vec_t v;
    v.kind = kind; v.wr = wr; v.addr = addr; v.data = data;
    v.x0 = x0; v.y0 = y0; v.y1 = y1; v.en = en; v.score = score;
    v.pend = pend; v.done = done; v.phase = phase;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    chipselect = 1'b0;
    write      = 1'b0;
    address    = 9'd0;
    writedata  = 32'd0;
    hcount     = 11'd5;
    vcount     = 10'd0;
  endtask

  task automatic set_inputs(input logic [1:0] kind, input logic wr,
                            input logic [8:0] a, input logic [31:0] d);
    chipselect = wr;
    write      = wr;
    address    = a;
    writedata  = d;
    case (kind)
      2'd1:    begin hcount = 11'd0; vcount = 10'd480; end
      2'd2:    begin hcount = 11'd1; vcount = 10'd480; end
      2'd3:    begin hcount = 11'd0; vcount = 10'd479; end
      default: begin hcount = 11'd5; vcount = 10'd0;   end
    endcase
  endtask

  // One clock cycle of stimulus; returns 1 ns after the capturing edge
  task automatic drive(input logic [1:0] kind, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    set_inputs(kind, wr, a, d);
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " live_x"},     64'(live_x),         64'd0);
    check({tag, " live_y"},     64'(live_y),         64'd0);
    check({tag, " live_en"},    64'(live_en),        64'd0);
    check({tag, " live_score"}, 64'(live_score),     64'd0);
    check({tag, " anim_phase"}, 64'(anim_phase),     64'd0);
    check({tag, " pending"},    64'(commit_pending), 64'd0);
    check({tag, " done"},       64'(commit_done),    64'd0);
  endtask

  localparam logic [15:0] S = 16'h1234;

  initial begin
    reset = 1'b1;
    set_idle();

    // Reset state, observed while reset is still held
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // kind wr addr data          x0  y0  y1  en score pend done ph
    vecs.push_back(mk(0, 1, 9'd0,   32'h0000_0164,   0,   0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9'd1,   32'd100,         0,   0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9'd13,  32'hFFFF_FFC1,   0,   0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9'd12,  32'hABCD_1234,   0,   0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9'd14,  32'd0,           0,   0,  0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2, 0, 9'd0,   32'd0,           0,   0,  0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(3, 0, 9'd0,   32'd0,           0,   0,  0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,         100, 100,  0, 1, S, 0, 1, 0));
    vecs.push_back(mk(0, 0, 9'd0,   32'd0,         100, 100,  0, 1, S, 0, 0, 0));
    // COMMIT coincident with a tick while IDLE only arms
    vecs.push_back(mk(0, 1, 9'd0,   32'd77,        100, 100,  0, 1, S, 0, 0, 0));
    vecs.push_back(mk(1, 1, 9'd14,  32'd0,         100, 100,  0, 1, S, 1, 0, 0));
    vecs.push_back(mk(0, 0, 9'd0,   32'd0,         100, 100,  0, 1, S, 1, 0, 0));
    // shadow write on the committing edge: live takes the old shadow (77)
    vecs.push_back(mk(1, 1, 9'd0,   32'd50,         77, 100,  0, 1, S, 0, 1, 0));
    vecs.push_back(mk(0, 1, 9'h100, 32'd200,        77, 100,  0, 1, S, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9'd16,  32'd200,        77, 100,  0, 1, S, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9'd14,  32'd0,          77, 100,  0, 1, S, 1, 0, 0));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100,  0, 1, S, 0, 1, 0));
    // COMMIT while ARMED changes nothing
    vecs.push_back(mk(0, 1, 9'd14,  32'd0,          50, 100,  0, 1, S, 1, 0, 0));
    vecs.push_back(mk(0, 1, 9'd14,  32'd0,          50, 100,  0, 1, S, 1, 0, 0));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100,  0, 1, S, 0, 1, 0));
    // sixth tick since reset: default period 6 steps the phase
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100,  0, 1, S, 0, 0, 1));
    // AUTO=1, period 0 (frozen phase)
    vecs.push_back(mk(0, 1, 9'd15,  32'h0000_0001,  50, 100,  0, 1, S, 0, 0, 1));
    vecs.push_back(mk(0, 1, 9'd3,   32'd11,         50, 100,  0, 1, S, 0, 0, 1));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100,  0, 1, S, 1, 0, 1));
    vecs.push_back(mk(0, 1, 9'd3,   32'd22,         50, 100,  0, 1, S, 1, 0, 1));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100, 22, 1, S, 0, 1, 1));
    vecs.push_back(mk(1, 1, 9'd3,   32'd33,         50, 100, 22, 1, S, 1, 0, 1));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100, 33, 1, S, 0, 1, 1));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100, 33, 1, S, 1, 0, 1));
    // AUTO=0, period 2
    vecs.push_back(mk(0, 1, 9'd15,  32'h0000_0200,  50, 100, 33, 1, S, 1, 0, 1));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100, 33, 1, S, 0, 1, 1));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100, 33, 1, S, 0, 0, 2));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100, 33, 1, S, 0, 0, 2));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100, 33, 1, S, 0, 0, 0));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100, 33, 1, S, 0, 0, 0));
    vecs.push_back(mk(1, 0, 9'd0,   32'd0,          50, 100, 33, 1, S, 0, 0, 1));
    vecs.push_back(mk(0, 1, 9'd14,  32'd0,          50, 100, 33, 1, S, 1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].kind, vecs[i].wr, vecs[i].addr, vecs[i].data);
      check($sformatf("row%0d x0", i),      64'(live_x[7:0]),    64'(vecs[i].x0));
      check($sformatf("row%0d y0", i),      64'(live_y[7:0]),    64'(vecs[i].y0));
      check($sformatf("row%0d y1", i),      64'(live_y[15:8]),   64'(vecs[i].y1));
      check($sformatf("row%0d en", i),      64'(live_en),        64'(vecs[i].en));
      check($sformatf("row%0d score", i),   64'(live_score),     64'(vecs[i].score));
      check($sformatf("row%0d pending", i), 64'(commit_pending), 64'(vecs[i].pend));
      check($sformatf("row%0d done", i),    64'(commit_done),    64'(vecs[i].done));
      check($sformatf("row%0d phase", i),   64'(anim_phase),     64'(vecs[i].phase));
    end

    // Asynchronous reset mid-cycle while ARMED with phase 1 and a loaded live bank
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");

    // Held reset ignores a coincident COMMIT write and tick
    set_inputs(2'd1, 1'b1, 9'd14, 32'd0);
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    reset = 1'b0;
    set_idle();

    // The pending commit was discarded: the next tick commits nothing
    drive(2'd1, 1'b0, 9'd0, 32'd0);
    check("post_reset done",    64'(commit_done),    64'd0);
    check("post_reset pending", 64'(commit_pending), 64'd0);
    check("post_reset live_x",  64'(live_x),         64'd0);
    check("post_reset live_en", 64'(live_en),        64'd0);

    // Period is back at 6: phase steps on the sixth tick, not before
    for (int t = 2; t <= 6; t++) begin
      drive(2'd1, 1'b0, 9'd0, 32'd0);
      check($sformatf("default_period tick%0d", t), 64'(anim_phase), (t == 6) ? 64'd1 : 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
